mem_access_unit: RTL
====================

# mem_access_unit

- Sits between the core's load/store path and the byte-wide `ram` block; drives its `addr`/`data_in`/`read_enable`/`write_enable` and consumes `data_out`.
- Turns one byte, halfword or word request into 1, 2 or 4 sequential single-byte RAM accesses, little-endian.
- Reassembles load data with sign/zero extension and returns a single response pulse per request.

## Interface
Parameters:
- ADDR_WIDTH, 5, RAM byte-address width; matches `ram` ADDR_WIDTH.
- RAM_DATA_WIDTH, 8, RAM word width; fixed at 8, the unit is byte-sequenced.
- WORD_WIDTH, 32, core-side data width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- req_signed  in  1  sign-extend loads (byte/half only).
- req_addr  in  ADDR_WIDTH  byte address of the lowest byte.
- req_wdata  in  WORD_WIDTH  store data; low bytes used.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  WORD_WIDTH  load result; 0 on store responses.
- rsp_err  out  1  misaligned access (see Configuration).
- ram_addr  out  ADDR_WIDTH  to `ram.addr`.
- ram_data_in  out  8  to `ram.data_in`.
- ram_read_enable  out  1  to `ram.read_enable`.
- ram_write_enable  out  1  to `ram.write_enable`.
- ram_data_out  in  8  from `ram.data_out`; valid one cycle after read_enable.

## Operation
- States: IDLE, WRITE, READ, DRAIN, RESP.
- IDLE:
  - req_ready=1.
  - When req_valid&&req_ready, latch addr/size/signed/wdata, set N = 1/2/4, clear index k.
  - Go to WRITE or READ.
- WRITE:
  - Each cycle: ram_write_enable=1, ram_addr=base+k, ram_data_in=wdata[8k+7:8k]; k++.
  - After byte N-1, go to RESP.
- READ:
  - Each cycle: ram_read_enable=1, ram_addr=base+k; k++.
  - From the second READ cycle on, capture ram_data_out into byte k-1 of the assembly register.
  - After issue N-1, go to DRAIN.
- DRAIN:
  - No enables asserted; capture final byte N-1.
  - Go to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_rdata = assembled value, sign- or zero-extended from 8N bits (word: unchanged); 0 for stores.
  - Go to IDLE.
- RAM outputs are decoded from registered state/k/base. In IDLE, DRAIN and RESP: enables=0, ram_addr=0, ram_data_in=0.
- Address arithmetic: base+k is ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH (e.g. word at 5'h1F touches 1F, 00, 01, 02).
- Only one request is ever outstanding; req_valid is ignored outside IDLE.
- rsp_rdata and rsp_err are held until the next RESP; consumers sample them only with rsp_valid.

## Timing
- Accept cycle = cycle 0 (handshake in IDLE).
- Store: WRITE in cycles 1..N; rsp_valid in cycle N+1; req_ready again in cycle N+2.
  - Byte 2, half 3, word 5 cycles from accept to rsp_valid.
- Load: READ in cycles 1..N; DRAIN in N+1; rsp_valid in N+2.
  - Byte 3, half 4, word 6 cycles.
- Back-to-back: the minimum gap between accepts is N+2 (store) or N+3 (load) cycles.
- Reset:
  - While rst=1, all outputs are 0 (req_ready included) and the state is IDLE.
  - req_ready=1 in the first cycle after rst deasserts.
- Reset mid-operation aborts immediately. Bytes already written stay in RAM; no response is produced.

## Configuration
- MISALIGN_CHECK_EN defined:
  - A half with addr[0]≠0, or a word with addr[1:0]≠0, goes from IDLE directly to RESP.
  - No RAM enables; rsp_err=1, rsp_rdata=0; response in cycle 1.
  - rsp_err=0 for aligned requests.
- Undefined: rsp_err is tied 0 and misaligned accesses proceed bytewise with wrap.

## Structure
- `data_types_pkg` additions:
  - `access_size_t` enum (SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10).
  - `mau_state_t` enum for the five states.
  - `WORD_WIDTH` localparam.
- One sub-module, `load_extend`: combinational; takes the assembled word, size and signed flag and returns the extended result.

## Test plan
- Store word 32'hDEADBEEF at 5'h04, then load word at 5'h04:
  - RAM[4..7] = EF, BE, AD, DE.
  - Store response 5 cycles after accept; load returns 32'hDEADBEEF 6 cycles after accept.
- RAM[8]=8'h80:
  - Signed byte load at 5'h08 -> 32'hFFFFFF80.
  - Unsigned byte load -> 32'h00000080.
- Half store 16'h1234 at 5'h1F, macro undefined -> RAM[1F]=34, RAM[00]=12; half load at 5'h1F returns 32'h00001234.
- With MISALIGN_CHECK_EN, word load at 5'h02:
  - No ram_read_enable.
  - rsp_valid with rsp_err=1 and rsp_rdata=0 in cycle 1.
- rst asserted in the 2nd WRITE cycle of a word store to 5'h10:
  - Only RAM[10] is updated; no rsp_valid.
  - req_ready=1 the cycle after rst drops.
- req_valid held high continuously with alternating requests:
  - Each accept occurs only when req_ready=1.
  - Exactly one rsp_valid per accept.

Source files
------------

// File: rtl/data_types_pkg.sv
// Shared types for the byte-sequenced memory access unit.
// Size and state encodings plus small helpers used by the top.
package data_types_pkg;

    localparam int WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } access_size_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_RESP
    } mau_state_t;

    // Size code 2'b11 behaves like a word.
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] addr_lo);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational sign/zero extension of an assembled load value.
// Word sizes pass through untouched.
module load_extend
    import data_types_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] word,
    input  logic [1:0]       size,
    input  logic             sign_en,
    output logic [WIDTH-1:0] result
);

    logic fill_b;
    logic fill_h;

    assign fill_b = sign_en & word[7];
    assign fill_h = sign_en & word[15];

    always_comb begin
        result = word;
        case (size)
            SIZE_B:  result = {{(WIDTH-8){fill_b}}, word[7:0]};
            SIZE_H:  result = {{(WIDTH-16){fill_h}}, word[15:0]};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Splits byte/half/word requests into single-byte RAM accesses.
// Define MISALIGN_CHECK_EN to reject misaligned half/word requests.
module mem_access_unit
    import data_types_pkg::*;
#(
    parameter int ADDR_WIDTH     = 5,
    parameter int RAM_DATA_WIDTH = 8,
    parameter int WORD_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [1:0]                req_size,
    input  logic                      req_signed,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [WORD_WIDTH-1:0]     req_wdata,
    output logic                      rsp_valid,
    output logic [WORD_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_WIDTH-1:0]     ram_addr,
    output logic [RAM_DATA_WIDTH-1:0] ram_data_in,
    output logic                      ram_read_enable,
    output logic                      ram_write_enable,
    input  logic [RAM_DATA_WIDTH-1:0] ram_data_out
);

    mau_state_t                state;
    logic [2:0]                k;
    logic [2:0]                nbytes;
    logic [ADDR_WIDTH-1:0]     base;
    logic [1:0]                size_q;
    logic                      sign_q;
    logic [WORD_WIDTH-1:0]     wdata_q;
    logic [WORD_WIDTH-1:0]     asm_q;
    logic [WORD_WIDTH-1:0]     asm_next;
    logic [WORD_WIDTH-1:0]     ext;
    logic                      rsp_valid_q;
    logic [WORD_WIDTH-1:0]     rsp_rdata_q;
    logic                      rsp_err_q;
    logic                      mis_req;
    logic [1:0]                cap_idx;
    logic                      last;

`ifdef MISALIGN_CHECK_EN
    assign mis_req = misaligned(req_size, req_addr[1:0]);
`else
    assign mis_req = 1'b0;
`endif

    assign last    = (k == nbytes - 3'd1);
    assign cap_idx = k[1:0] - 2'd1;

    // Read data trails its issue by one cycle, so byte k-1 lands now.
    always_comb begin
        asm_next = asm_q;
        if ((state == ST_READ && k != 3'd0) || state == ST_DRAIN)
            asm_next[{cap_idx, 3'b000} +: 8] = ram_data_out;
    end

    load_extend #(
        .WIDTH (WORD_WIDTH)
    ) u_ext (
        .word    (asm_next),
        .size    (size_q),
        .sign_en (sign_q),
        .result  (ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            k           <= '0;
            nbytes      <= '0;
            base        <= '0;
            size_q      <= '0;
            sign_q      <= 1'b0;
            wdata_q     <= '0;
            asm_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        base    <= req_addr;
                        size_q  <= req_size;
                        sign_q  <= req_signed;
                        wdata_q <= req_wdata;
                        nbytes  <= byte_count(req_size);
                        k       <= '0;
                        asm_q   <= '0;
                        if (mis_req) begin
                            state       <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= '0;
                            rsp_err_q   <= 1'b1;
                        end else if (req_write) begin
                            state <= ST_WRITE;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    k <= k + 3'd1;
                    if (last) begin
                        state       <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                ST_READ: begin
                    asm_q <= asm_next;
                    k     <= k + 3'd1;
                    if (last)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    asm_q       <= asm_next;
                    state       <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= ext;
                    rsp_err_q   <= 1'b0;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Reset forces every output low, even mid-transfer.
    assign req_ready        = !rst && state == ST_IDLE;
    assign ram_write_enable = !rst && state == ST_WRITE;
    assign ram_read_enable  = !rst && state == ST_READ;

    assign ram_addr = (ram_write_enable || ram_read_enable)
                    ? base + ADDR_WIDTH'(k) : '0;
    assign ram_data_in = ram_write_enable
                       ? wdata_q[{k[1:0], 3'b000} +: 8] : '0;

    assign rsp_valid = !rst && rsp_valid_q;
    assign rsp_rdata = rst ? '0 : rsp_rdata_q;
    assign rsp_err   = !rst && rsp_err_q;

endmodule
